// File: rtl/rider_steer_sm.sv
// Rider-presence and steer-enable sequencer: qualifies held load-cell samples,
// applies weight hysteresis and a level-settle timer before granting steering.
module rider_steer_sm #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter bit          FAST_SIM     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  localparam int unsigned TmrW = FAST_SIM ? 15 : 26;
  localparam logic [TmrW-1:0] TmrOne = TmrW'(1);

  typedef enum logic [1:0] {StIdle, StWait, StSteer} state_e;

  state_e            state_q, state_d;
  logic [11:0]       lft_s_q, rght_s_q;
  logic [TmrW-1:0]   tmr_q, tmr_d;

  logic [12:0] sum;
  logic [11:0] diff;
  logic [12:0] off_thr;
  logic        lvl, tilt, rider_on, rider_gone, tmr_full;

  always_comb begin
    sum        = {1'b0, lft_s_q} + {1'b0, rght_s_q};
    diff       = (lft_s_q >= rght_s_q) ? (lft_s_q - rght_s_q) : (rght_s_q - lft_s_q);
    off_thr    = {1'b0, MIN_RIDER_WT - WT_HYST};
    lvl        = {1'b0, diff} < (sum >> 2);
    tilt       = {1'b0, diff} > (sum - (sum >> 4));
    rider_on   = sum > {1'b0, MIN_RIDER_WT};
    rider_gone = sum < off_thr;
    tmr_full   = &tmr_q;
  end

  always_comb begin
    state_d = state_q;
    if (!pwr_up) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (rider_on) state_d = StWait;
        StWait: begin
          if (rider_gone)          state_d = StIdle;
          else if (lvl && tmr_full) state_d = StSteer;
        end
        StSteer: begin
          if (rider_gone) state_d = StIdle;
          else if (tilt)  state_d = StWait;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Timer only runs while staying in WAIT on a level sample; anything else zeroes it.
  always_comb begin
    tmr_d = '0;
    if (state_q == StWait && state_d == StWait && lvl) begin
      tmr_d = tmr_full ? tmr_q : tmr_q + TmrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lft_s_q   <= '0;
      rght_s_q  <= '0;
      tmr_q     <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      if (ld_vld) begin
        lft_s_q  <= lft_ld;
        rght_s_q <= rght_ld;
      end
      en_steer  <= (state_d == StSteer);
      rider_off <= (state_d == StIdle);
    end
  end

endmodule

// File: tb/tb_rider_steer_sm.sv
// Bench for rider_steer_sm: hand-derived vector table, directed settle/lean/power
// sequences, and randomized traffic checked against an arithmetic reference model.
module tb_rider_steer_sm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_up = 1'b0;
  logic        ld_vld = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic        en_steer, rider_off;

  rider_steer_sm #(
    .MIN_RIDER_WT(12'h200),
    .WT_HYST     (12'h040),
    .FAST_SIM    (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_up   (pwr_up),
    .ld_vld   (ld_vld),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .en_steer (en_steer),
    .rider_off(rider_off)
  );

  always #5 clk = ~clk;

  localparam int TMAX = 32767;

  int total = 0;
  int bad = 0;

  // Reference model: 0 = idle, 1 = waiting to settle, 2 = steering.
  int m_st = 0;
  int m_l = 0, m_r = 0, m_cnt = 0;
  bit m_en = 1'b0, m_off = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit pwr, input bit vld,
                            input int l, input int r);
    int sum, diff, nxt;
    bit lvl, tilt, on, off;
    if (!rst) begin
      m_st = 0; m_l = 0; m_r = 0; m_cnt = 0;
    end else begin
      sum  = m_l + m_r;
      diff = (m_l > m_r) ? m_l - m_r : m_r - m_l;
      lvl  = diff < sum / 4;
      tilt = diff > sum - sum / 16;
      on   = sum > 512;
      off  = sum < 448;
      nxt  = m_st;
      if (!pwr) nxt = 0;
      else if (m_st == 0) begin
        if (on) nxt = 1;
      end else if (m_st == 1) begin
        if (off) nxt = 0;
        else if (lvl && m_cnt == TMAX) nxt = 2;
      end else begin
        if (off) nxt = 0;
        else if (tilt) nxt = 1;
      end
      if (m_st == 1 && nxt == 1 && lvl) m_cnt = (m_cnt < TMAX) ? m_cnt + 1 : TMAX;
      else m_cnt = 0;
      m_st = nxt;
      if (vld) begin
        m_l = l; m_r = r;
      end
    end
    m_en  = (m_st == 2);
    m_off = (m_st == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, pwr_up, ld_vld, int'(lft_ld), int'(rght_ld));
    #1;
    check("model", {30'd0, en_steer, rider_off}, {30'd0, m_en, m_off});
  endtask

  task automatic load(input logic [11:0] l, input logic [11:0] r);
    lft_ld = l; rght_ld = r; ld_vld = 1'b1;
    tick();
    ld_vld = 1'b0;
  endtask

  task automatic count_to_steer(input string name);
    int n = 0;
    while (en_steer !== 1'b1 && n < 40000) begin
      tick();
      n++;
    end
    check(name, n, 32768);
  endtask

  function automatic logic [11:0] pick_ld();
    case ($urandom_range(0, 3))
      0: return 12'($urandom);
      1: return 12'(32'h0C0 + $urandom_range(0, 64));
      2: return 12'(32'h0F0 + $urandom_range(0, 32));
      default: return 12'h0;
    endcase
  endfunction

  typedef struct {
    bit          rst_n;
    bit          pwr;
    bit          vld;
    logic [11:0] l;
    logic [11:0] r;
    bit          en;
    bit          off;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 12'h180, 12'h180, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 12'h300, 12'h080, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 12'h100, 12'h0C0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 12'h0E0, 12'h0DF, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 12'h100, 12'h100, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 12'h101, 12'h100, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 12'h300, 12'h080, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      rst_n = tbl[i].rst_n; pwr_up = tbl[i].pwr; ld_vld = tbl[i].vld;
      lft_ld = tbl[i].l; rght_ld = tbl[i].r;
      tick();
      check($sformatf("vec%0d", i), {30'd0, en_steer, rider_off},
            {30'd0, tbl[i].en, tbl[i].off});
    end
    ld_vld = 1'b0;

    // Unlevel rider held in WAIT never gets steering.
    repeat (1000) tick();
    check("unlevel_no_steer", {31'd0, en_steer}, 32'd0);

    // Re-level: full count from zero, measured from the capture edge.
    load(12'h1C0, 12'h1C0);
    count_to_steer("relevel_count");

    // Between thresholds: steering holds.
    load(12'h0F0, 12'h0F0);
    repeat (50) tick();
    check("hyst_hold", {30'd0, en_steer, rider_off}, 32'b10);

    // Weight drop that is also a gross lean: exit to IDLE wins.
    load(12'h1B0, 12'h000);
    tick();
    check("off_beats_tilt", {30'd0, en_steer, rider_off}, 32'b01);

    // Mount from IDLE: rider_off falls 2 clks after ld_vld, steer 32768 clks later.
    load(12'h180, 12'h180);
    check("mount_capture", {31'd0, rider_off}, 32'd1);
    tick();
    check("mount_wait", {31'd0, rider_off}, 32'd0);
    count_to_steer("mount_count");

    // Lean drops back to WAIT; timer restarts so steer stays off after re-level.
    load(12'h3F0, 12'h000);
    tick();
    check("lean_wait", {30'd0, en_steer, rider_off}, 32'b00);
    load(12'h180, 12'h180);
    repeat (500) tick();
    check("lean_restart", {31'd0, en_steer}, 32'd0);

    // Power drop and reset abort the settle.
    pwr_up = 1'b0;
    tick();
    check("pwr_drop", {30'd0, en_steer, rider_off}, 32'b01);
    pwr_up = 1'b1;
    tick();
    check("pwr_reraise", {31'd0, rider_off}, 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_reset", {31'd0, rider_off}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("post_reset_clear", {31'd0, rider_off}, 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 499) != 0);
      pwr_up  = ($urandom_range(0, 31) != 0);
      ld_vld  = ($urandom_range(0, 7) == 0);
      lft_ld  = pick_ld();
      rght_ld = pick_ld();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
